stap_responder: RTL and testbench
=================================

Name: stap_responder

Overview:
- Secondary-TAP (STAP) endpoint: receives the gated STCK/STMS/STDI/STRST_N bundle and returns STDO.
- Implements an IEEE 1149.1-style 16-state TAP controller with a 4-bit IR and three data registers: BYPASS, IDCODE, 8-bit USER.
- USER register contents are exported as `user_reg` to drive local configuration on the secondary die/block.

Parameters:
- IR_WIDTH, 4, instruction register width.
- IDCODE_VALUE, 32'h1000_0001, value captured by IDCODE; bit 0 must be 1.
- USER_WIDTH, 8, USER data register width.
- USER_RESET, 8'h00, reset value of `user_reg`.

Ports:
- TCK  input  1  clock (the STCK net); all state changes on rising edge.
- RST  input  1  synchronous active-high reset.
- STMS  input  1  TAP mode select, sampled on the rising edge of TCK.
- STDI  input  1  serial data in, sampled on the rising edge of TCK.
- STRST_N  input  1  TAP reset, active-low, sampled synchronously.
- STDO  output  1  serial data out.
- user_reg  output  USER_WIDTH  USER register parallel output.
- user_update  output  1  one-cycle pulse when `user_reg` is written.
- tap_state  output  4  current TAP state encoding, for debug/verification.
- ir_value  output  IR_WIDTH  current latched instruction.

Behaviour:
- Reset when RST=1 or STRST_N=0 on a rising edge:
  - state=TLR, ir_value=IDCODE (4'h1), shift registers=0, STDO=0, user_update=0.
  - `user_reg`=USER_RESET on RST only; STRST_N does not clear `user_reg`.
  - RST has priority when both are asserted.
- States, with tap_state encoding:
  - TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PA_DR=6, EX2_DR=7, UPD_DR=8.
  - SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PA_IR=13, EX2_IR=14, UPD_IR=15.
- Transitions: standard 1149.1, next state chosen by STMS on each rising edge.
  - TLR: 1 stays, 0 goes to RTI.
  - RTI: 1 goes to SEL_DR.
  - SEL_DR: 1 goes to SEL_IR, 0 goes to CAP_DR.
  - SEL_IR: 1 goes to TLR, 0 goes to CAP_IR.
  - CAP: 1 goes to EX1, 0 goes to SH.
  - SH: 1 goes to EX1.
  - EX1: 1 goes to UPD, 0 goes to PA.
  - PA: 1 goes to EX2.
  - EX2: 1 goes to UPD, 0 goes to SH.
  - UPD: 1 goes to SEL_DR, 0 goes to RTI.
  - Five consecutive STMS=1 reach TLR from any state.
- Instruction decode:
  - 4'h1 selects IDCODE.
  - 4'h2 selects USER.
  - 4'hF and all other codes select BYPASS (1-bit).
- IR path:
  - CAP_IR: ir_shift <= 4'b0001.
  - SH_IR: ir_shift <= {STDI, ir_shift[3:1]}.
  - UPD_IR: ir_value <= ir_shift.
- DR path, capture in CAP_DR:
  - IDCODE loads IDCODE_VALUE.
  - USER loads current `user_reg`.
  - BYPASS loads 0.
- DR path, shift in SH_DR: the selected register shifts right, STDI enters its MSB (32, 8 or 1 bit wide).
- DR path, update in UPD_DR with USER selected: user_reg <= user_shift and user_update=1 for exactly that one cycle. No side effect for other instructions.
- STDO:
  - Registered, updated on the same edge as the shift.
  - In SH_IR/SH_DR it equals the LSB of the active shift register before that edge's shift, so the first shifted-out bit appears on STDO the cycle after entering SH.
  - 0 in all other states.
- Pause states hold all shift registers.
- Reset mid-shift discards the shift contents; ir_value returns to IDCODE.

Decomposition:
- Package `stap_pkg`:
  - tap_state_t enum with the encodings above.
  - Instruction constants INSTR_IDCODE, INSTR_USER, INSTR_BYPASS.
  - Default IDCODE_VALUE.
- Sub-module `tap_fsm`: STMS-driven 16-state controller, outputs state only.
- Top module: IR, DR, and STDO logic.

Test Plan:
- RST=1 for 2 cycles, then hold STMS=1 for 3 cycles -> tap_state=0, ir_value=4'h1, user_reg=8'h00, STDO=0.
- From TLR, STMS sequence 0,1,0,0 then 32 cycles in SH_DR (STMS=1 on the last) -> STDO stream LSB-first equals 32'h1000_0001.
- Load IR=4'h2 (Shift-IR STDI 0,1,0,0), then shift DR with 8'hA5 LSB-first and exit through UPD_DR -> user_reg=8'hA5, user_update high exactly 1 cycle. Capture again -> STDO shifts out 8'hA5.
- IR=4'hF, shift STDI pattern 1,0,1,1 -> STDO returns the same pattern delayed by 1 bit, starting with a leading 0.
- IR=4'h7 (undefined) -> behaves as BYPASS; user_reg unchanged.
- Mid-SH_DR of USER, drive STRST_N=0 for 1 cycle -> tap_state=0, ir_value=4'h1, user_reg keeps its previous value (8'hA5). Same scenario with RST -> user_reg=8'h00.

Source files
------------

// File: rtl/stap_pkg.sv
// Shared types and constants for the secondary-TAP endpoint.
// State encodings are exported on tap_state, so their values are fixed.
package stap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  localparam logic [3:0]  INSTR_IDCODE   = 4'h1;
  localparam logic [3:0]  INSTR_USER     = 4'h2;
  localparam logic [3:0]  INSTR_BYPASS   = 4'hF;
  localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0001;

endpackage

// File: rtl/stap_responder_tap_fsm.sv
// 16-state TAP controller; state advances on every TCK rising edge from STMS.
// No backpressure: one transition per clock, synchronous reset to TLR.
module tap_fsm
  import stap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q, state_d;

  always_ff @(posedge tck_i) begin
    if (rst_i) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = tms_i ? TLR    : RTI;
      RTI:    state_d = tms_i ? SEL_DR : RTI;
      SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms_i ? UPD_DR : PA_DR;
      PA_DR:  state_d = tms_i ? EX2_DR : PA_DR;
      EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms_i ? SEL_DR : RTI;
      SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
      CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms_i ? UPD_IR : PA_IR;
      PA_IR:  state_d = tms_i ? EX2_IR : PA_IR;
      EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms_i ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/stap_responder.sv
// STAP endpoint: IR plus IDCODE/USER/BYPASS data registers behind a TAP FSM.
// STDO is registered (one TCK behind the shift register LSB); no backpressure.
module stap_responder
  import stap_pkg::*;
#(
  parameter int                    IR_WIDTH     = 4,
  parameter logic [31:0]           IDCODE_VALUE = IDCODE_DEFAULT,
  parameter int                    USER_WIDTH   = 8,
  parameter logic [USER_WIDTH-1:0] USER_RESET   = 8'h00
) (
  input  logic                  TCK,
  input  logic                  RST,
  input  logic                  STMS,
  input  logic                  STDI,
  input  logic                  STRST_N,
  output logic                  STDO,
  output logic [USER_WIDTH-1:0] user_reg,
  output logic                  user_update,
  output logic [3:0]            tap_state,
  output logic [IR_WIDTH-1:0]   ir_value
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(INSTR_USER);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_t state;
  logic       tap_rst;

  logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0]   ir_value_q, ir_value_d;
  logic [31:0]           idcode_q, idcode_d;
  logic [USER_WIDTH-1:0] user_shift_q, user_shift_d;
  logic                  bypass_q, bypass_d;
  logic                  stdo_q, stdo_d;
  logic [USER_WIDTH-1:0] user_reg_q;
  logic                  user_update_q, user_wr;
  logic                  sel_idcode, sel_user;

  assign tap_rst = RST | ~STRST_N;

  tap_fsm u_fsm (
    .tck_i   (TCK),
    .rst_i   (tap_rst),
    .tms_i   (STMS),
    .state_o (state)
  );

  // Any code other than IDCODE or USER falls through to BYPASS.
  assign sel_idcode = (ir_value_q == IR_IDCODE);
  assign sel_user   = (ir_value_q == IR_USER);
  assign user_wr    = (state == UPD_DR) && sel_user && !tap_rst;

  always_comb begin
    ir_shift_d   = ir_shift_q;
    ir_value_d   = ir_value_q;
    idcode_d     = idcode_q;
    user_shift_d = user_shift_q;
    bypass_d     = bypass_q;
    stdo_d       = 1'b0;
    case (state)
      TLR:    ir_value_d = IR_IDCODE;
      CAP_IR: ir_shift_d = IR_CAPTURE;
      SH_IR: begin
        stdo_d     = ir_shift_q[0];
        ir_shift_d = {STDI, ir_shift_q[IR_WIDTH-1:1]};
      end
      UPD_IR: ir_value_d = ir_shift_q;
      CAP_DR: begin
        if (sel_idcode)    idcode_d     = IDCODE_VALUE;
        else if (sel_user) user_shift_d = user_reg_q;
        else               bypass_d     = 1'b0;
      end
      SH_DR: begin
        if (sel_idcode) begin
          stdo_d   = idcode_q[0];
          idcode_d = {STDI, idcode_q[31:1]};
        end else if (sel_user) begin
          stdo_d       = user_shift_q[0];
          user_shift_d = {STDI, user_shift_q[USER_WIDTH-1:1]};
        end else begin
          stdo_d   = bypass_q;
          bypass_d = STDI;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (tap_rst) begin
      ir_shift_q    <= '0;
      ir_value_q    <= IR_IDCODE;
      idcode_q      <= '0;
      user_shift_q  <= '0;
      bypass_q      <= 1'b0;
      stdo_q        <= 1'b0;
      user_update_q <= 1'b0;
    end else begin
      ir_shift_q    <= ir_shift_d;
      ir_value_q    <= ir_value_d;
      idcode_q      <= idcode_d;
      user_shift_q  <= user_shift_d;
      bypass_q      <= bypass_d;
      stdo_q        <= stdo_d;
      user_update_q <= user_wr;
    end
  end

  // Only the hard reset clears the exported configuration; a TAP reset keeps it.
  always_ff @(posedge TCK) begin
    if (RST)          user_reg_q <= USER_RESET;
    else if (user_wr) user_reg_q <= user_shift_q;
  end

  assign STDO        = stdo_q;
  assign user_reg    = user_reg_q;
  assign user_update = user_update_q;
  assign tap_state   = state;
  assign ir_value    = ir_value_q;

endmodule

// File: tb/tb_stap_responder.sv
// Scoreboard bench for stap_responder: expected STDO bits are queued per shift
// and popped as each shift edge produces output.
module tb_stap_responder;

  logic       TCK = 1'b0;
  logic       RST = 1'b1;
  logic       STMS = 1'b1;
  logic       STDI = 1'b0;
  logic       STRST_N = 1'b1;
  logic       STDO;
  logic [7:0] user_reg;
  logic       user_update;
  logic [3:0] tap_state;
  logic [3:0] ir_value;

  int   errors = 0;
  int   checks = 0;
  int   pulse_cnt = 0;
  logic exp_q[$];

  stap_responder dut (
    .TCK         (TCK),
    .RST         (RST),
    .STMS        (STMS),
    .STDI        (STDI),
    .STRST_N     (STRST_N),
    .STDO        (STDO),
    .user_reg    (user_reg),
    .user_update (user_update),
    .tap_state   (tap_state),
    .ir_value    (ir_value)
  );

  always #5 TCK = ~TCK;

  always @(negedge TCK) if (user_update === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic tms, input logic tdi);
    STMS = tms;
    STDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      check(tag, STDO, e);
    end
  endtask

  // From RTI: load an instruction and return to RTI.
  task automatic load_ir(input logic [3:0] code);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    check("sh_ir_state", tap_state, 11);
    for (int i = 0; i < 4; i++) exp_q.push_back((i == 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, code[i]);
      pop_check("ir_out");
    end
    tick(1, 0);
    tick(0, 0);
    check("ir_value", ir_value, code);
    check("rti_after_ir", tap_state, 1);
  endtask

  // From RTI: capture, shift 'width' bits LSB-first, update, return to RTI.
  task automatic shift_dr(input int width, input logic [31:0] din, input logic [31:0] dout);
    tick(1, 0); tick(0, 0); tick(0, 0);
    check("sh_dr_state", tap_state, 4);
    for (int i = 0; i < width; i++) exp_q.push_back(dout[i]);
    for (int i = 0; i < width; i++) begin
      tick(i == width - 1, din[i]);
      pop_check("dr_out");
    end
    check("ex1_dr_state", tap_state, 5);
    tick(1, 0);
    tick(0, 0);
    check("rti_after_dr", tap_state, 1);
  endtask

  int p0;

  initial begin
    // Reset and idle in TLR
    tick(1, 0);
    tick(1, 0);
    RST = 1'b0;
    tick(1, 0); tick(1, 0); tick(1, 0);
    check("rst_state", tap_state, 0);
    check("rst_ir", ir_value, 4'h1);
    check("rst_user", user_reg, 8'h00);
    check("rst_stdo", STDO, 0);
    check("rst_upd", user_update, 0);

    // IDCODE read straight out of reset
    tick(0, 0);
    check("rti_state", tap_state, 1);
    shift_dr(32, 32'h0, 32'h1000_0001);
    check("stdo_idle", STDO, 0);

    // USER write then read-back
    load_ir(4'h2);
    p0 = pulse_cnt;
    shift_dr(8, 32'hA5, 32'h00);
    check("user_reg_wr", user_reg, 8'hA5);
    check("user_upd_hi", user_update, 1);
    tick(0, 0);
    check("user_upd_lo", user_update, 0);
    tick(0, 0);
    check("user_upd_pulses", 32'(pulse_cnt - p0), 1);
    shift_dr(8, 32'hA5, 32'hA5);
    tick(0, 0);

    // Explicit BYPASS
    load_ir(4'hF);
    p0 = pulse_cnt;
    shift_dr(4, 32'hD, 32'hA);
    tick(0, 0); tick(0, 0);
    check("byp_no_pulse", 32'(pulse_cnt - p0), 0);

    // Undefined code behaves as BYPASS, user_reg untouched
    load_ir(4'h7);
    p0 = pulse_cnt;
    shift_dr(4, 32'hD, 32'hA);
    tick(0, 0); tick(0, 0);
    check("undef_user", user_reg, 8'hA5);
    check("undef_no_pulse", 32'(pulse_cnt - p0), 0);

    // TAP reset mid-shift keeps user_reg
    load_ir(4'h2);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(i[0] ? 1'b0 : 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1);
      pop_check("mid_out");
    end
    STRST_N = 1'b0;
    tick(0, 0);
    STRST_N = 1'b1;
    check("trst_state", tap_state, 0);
    check("trst_ir", ir_value, 4'h1);
    check("trst_user", user_reg, 8'hA5);
    check("trst_stdo", STDO, 0);

    // Hard reset mid-shift clears user_reg
    tick(0, 0);
    load_ir(4'h2);
    tick(1, 0); tick(0, 0); tick(0, 0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(0, 0);
      pop_check("mid2_out");
    end
    RST = 1'b1;
    tick(0, 0);
    RST = 1'b0;
    check("hrst_state", tap_state, 0);
    check("hrst_ir", ir_value, 4'h1);
    check("hrst_user", user_reg, 8'h00);
    check("hrst_stdo", STDO, 0);
    check("hrst_upd", user_update, 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
